// File: rtl/jtcps2_busarb.sv
// Bus arbiter for the three CPS2 DMA engines (object, palette, scroll).
// Requests the 68000 bus, hands it round-robin to one DMA at a time, chains
// up to MAXCHAIN grants per bus tenure and revokes stuck grants with a
// cen-tick watchdog that blocks the offender until it drops its request.
module jtcps2_busarb #(
    parameter int TMO_W    = 12,
    parameter int MAXCHAIN = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       busreq,
    input  logic       busack,
    output logic [1:0] owner,
    output logic       timeout,
    input  logic       clr_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT,
        ST_SWITCH,
        ST_REL
    } state_t;

    localparam logic [1:0] NO_OWNER = 2'd3;
    // Revoking when the counter is one short of all-ones means the grant
    // lasts exactly 2^TMO_W-1 cen ticks and the counter lands on all-ones.
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t           state_q;
    logic [2:0]       gnt_q;
    logic             busreq_q;
    logic [1:0]       owner_q;
    logic             timeout_q;
    logic [1:0]       chain_q;
    logic [2:0]       block_q;
    logic [TMO_W-1:0] wdog_q;
    logic [1:0]       last_owner_q;

    logic [2:0] elig;
    logic [2:0] others;
    logic [1:0] pick;
    logic [1:0] chain_d;
    logic       owner_req;
    logic       ack_lost;

    assign gnt     = gnt_q;
    assign busreq  = busreq_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;

    assign elig      = req & ~block_q;
    assign others    = elig & ~gnt_q;
    assign owner_req = |(req & gnt_q);
    assign chain_d   = (chain_q == 2'd3) ? 2'd3 : chain_q + 2'd1;
    // Losing BGACK aborts a grant on any clk edge, not just cen edges.
    assign ack_lost  = (state_q == ST_GRANT || state_q == ST_SWITCH) && !busack;

    // Round-robin winner: search starts just after the last owner.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        pick = 2'd0;
        case (last_owner_q)
            2'd0:    pick = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
            2'd1:    pick = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
            default: pick = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
        endcase
    end

    // Arbitration FSM with registered grant, bus request, owner and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 3'b000;
            busreq_q     <= 1'b0;
            owner_q      <= NO_OWNER;
            timeout_q    <= 1'b0;
            chain_q      <= 2'd0;
            block_q      <= 3'b000;
            wdog_q       <= '0;
            last_owner_q <= 2'd2;
        end else begin
            // NOTE: non-blocking assignments make all state update together; later
            // assignments in this block deliberately override earlier ones.
            if (clr_err) timeout_q <= 1'b0;
            if (cen) block_q <= block_q & req;

            if (ack_lost) begin
                gnt_q    <= 3'b000;
                owner_q  <= NO_OWNER;
                busreq_q <= 1'b0;
                state_q  <= ST_REL;
            end else if (cen) begin
                case (state_q)
                    ST_IDLE: begin
                        if (|req) begin
                            busreq_q <= 1'b1;
                            chain_q  <= 2'd0;
                            state_q  <= ST_WAIT;
                        end
                    end
                    ST_WAIT, ST_SWITCH: begin
                        // SWITCH reaches here on its single gap tick with busack still high.
                        if (busack || state_q == ST_SWITCH) begin
                            if (|elig) begin
                                gnt_q        <= 3'b001 << pick;
                                owner_q      <= pick;
                                last_owner_q <= pick;
                                wdog_q       <= '0;
                                state_q      <= ST_GRANT;
                            end else begin
                                busreq_q <= 1'b0;
                                state_q  <= ST_REL;
                            end
                        end
                    end
                    ST_GRANT: begin
                        if (!owner_req) begin
                            gnt_q   <= 3'b000;
                            owner_q <= NO_OWNER;
                            chain_q <= chain_d;
                            if (|others && int'(chain_d) < MAXCHAIN) begin
                                state_q <= ST_SWITCH;
                            end else begin
                                busreq_q <= 1'b0;
                                state_q  <= ST_REL;
                            end
                        end else if (wdog_q == WDOG_LAST) begin
                            wdog_q    <= '1;
                            gnt_q     <= 3'b000;
                            owner_q   <= NO_OWNER;
                            timeout_q <= 1'b1;
                            block_q   <= (block_q & req) | gnt_q;
                            busreq_q  <= 1'b0;
                            state_q   <= ST_REL;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
                    ST_REL: begin
                        busreq_q <= 1'b0;
                        if (!busack) state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtcps2_busarb.sv
// Directed bench for jtcps2_busarb: a vector table for the basic tenure
// sequences, then hand-written sequences for abort, reset, watchdog and cen gating.
module tb_jtcps2_busarb;

    logic       rst;
    logic       clk;
    logic       cen;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       busreq;
    logic       busack;
    logic [1:0] owner;
    logic       timeout;
    logic       clr_err;

    int n_checks = 0;
    int n_err    = 0;

    jtcps2_busarb #(.TMO_W(4), .MAXCHAIN(2)) dut (
        .rst    (rst),
        .clk    (clk),
        .cen    (cen),
        .req    (req),
        .gnt    (gnt),
        .busreq (busreq),
        .busack (busack),
        .owner  (owner),
        .timeout(timeout),
        .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] req;
        logic       ack;
        logic [2:0] gnt;
        logic       busreq;
        logic [1:0] owner;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] r, input logic a, input logic [2:0] g,
                                input logic b, input logic [1:0] o, input string n);
        vec_t v;
        v.req = r; v.ack = a; v.gnt = g; v.busreq = b; v.owner = o; v.name = n;
        vecs.push_back(v);
    endfunction

    // Observed outputs packed as {gnt, busreq, owner, timeout}.
    function automatic logic [6:0] obs();
        return {gnt, busreq, owner, timeout};
    endfunction

    function automatic logic [6:0] ex(input logic [2:0] g, input logic b,
                                      input logic [1:0] o, input logic t);
        return {g, b, o, t};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got gnt/busreq/owner/timeout=%b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic a, input logic c, input logic e);
        req = r; busack = a; cen = c; clr_err = e;
    endtask

    task automatic step(input logic [2:0] r, input logic a, input logic c, input logic e);
        drive(r, a, c, e);
        @(posedge clk);
        #1;
    endtask

    // Three clk edges with cen low, then one with cen high.
    task automatic qstep(input logic [2:0] r, input logic a, input logic e);
        for (int i = 0; i < 3; i++) step(r, a, 1'b0, e);
        step(r, a, 1'b1, e);
    endtask

    initial begin
        rst = 1'b1;
        drive(3'b000, 1'b0, 1'b1, 1'b0);
        #3;
        check("reset_async", obs(), ex(3'b000, 1'b0, 2'd3, 1'b0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset_hold", obs(), ex(3'b000, 1'b0, 2'd3, 1'b0));

        // Chain of two grants then a new tenure starting at requester 2.
        add(3'b111, 0, 3'b000, 1, 3, "chain_req");
        add(3'b111, 1, 3'b001, 1, 0, "chain_g0");
        add(3'b110, 1, 3'b000, 1, 3, "chain_switch");
        add(3'b110, 1, 3'b010, 1, 1, "chain_g1");
        add(3'b100, 1, 3'b000, 0, 3, "chain_limit_rel");
        add(3'b100, 0, 3'b000, 0, 3, "chain_rel_wait");
        add(3'b100, 0, 3'b000, 1, 3, "chain_idle_req");
        add(3'b100, 1, 3'b100, 1, 2, "chain_g2_next");
        add(3'b000, 1, 3'b000, 0, 3, "chain_g2_rel");
        add(3'b000, 0, 3'b000, 0, 3, "chain_idle");
        // Single requester, busack three clocks after busreq.
        add(3'b001, 0, 3'b000, 1, 3, "single_busreq");
        add(3'b001, 0, 3'b000, 1, 3, "single_wait1");
        add(3'b001, 0, 3'b000, 1, 3, "single_wait2");
        add(3'b001, 1, 3'b001, 1, 0, "single_gnt");
        add(3'b001, 1, 3'b001, 1, 0, "single_hold");
        add(3'b000, 1, 3'b000, 0, 3, "single_rel");
        add(3'b000, 1, 3'b000, 0, 3, "single_rel_ack");
        add(3'b000, 0, 3'b000, 0, 3, "single_to_idle");
        add(3'b001, 0, 3'b000, 1, 3, "single_idle_proof");
        add(3'b001, 1, 3'b001, 1, 0, "single_regnt");
        add(3'b000, 1, 3'b000, 0, 3, "single_rel2");
        add(3'b000, 0, 3'b000, 0, 3, "single_idle2");
        // Request withdrawn while waiting for busack.
        add(3'b001, 0, 3'b000, 1, 3, "wdrop_req");
        add(3'b000, 0, 3'b000, 1, 3, "wdrop_wait");
        add(3'b000, 1, 3'b000, 0, 3, "wdrop_no_gnt");
        add(3'b000, 0, 3'b000, 0, 3, "wdrop_idle");

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].ack, 1'b1, 1'b0);
            check(vecs[i].name, obs(), ex(vecs[i].gnt, vecs[i].busreq, vecs[i].owner, 1'b0));
        end

        // busack lost during GRANT while cen is low.
        step(3'b001, 0, 1, 0);
        step(3'b001, 1, 1, 0);
        check("ack_gnt", obs(), ex(3'b001, 1, 2'd0, 0));
        step(3'b001, 1, 0, 0);
        check("ack_cen0_hold", obs(), ex(3'b001, 1, 2'd0, 0));
        step(3'b001, 0, 0, 0);
        check("ack_lost_drop", obs(), ex(3'b000, 0, 2'd3, 0));
        step(3'b001, 0, 0, 0);
        step(3'b000, 0, 1, 0);
        step(3'b001, 0, 1, 0);
        check("ack_back_idle", obs(), ex(3'b000, 1, 2'd3, 0));
        step(3'b000, 1, 1, 0);
        step(3'b000, 0, 1, 0);
        check("ack_drain", obs(), ex(3'b000, 0, 2'd3, 0));

        // Reset pulse in the middle of a grant.
        step(3'b011, 0, 1, 0);
        step(3'b011, 1, 1, 0);
        check("rst_pre_gnt", obs(), ex(3'b010, 1, 2'd1, 0));
        rst = 1'b1;
        #1;
        check("rst_mid_grant", obs(), ex(3'b000, 0, 2'd3, 0));
        #1;
        rst = 1'b0;
        busack = 1'b0;
        step(3'b011, 0, 1, 0);
        step(3'b011, 1, 1, 0);
        check("rst_restart_g0", obs(), ex(3'b001, 1, 2'd0, 0));
        step(3'b000, 1, 1, 0);
        step(3'b000, 0, 1, 0);

        // Watchdog with cen every clk: 15 ticks then revoke.
        step(3'b010, 0, 1, 0);
        step(3'b010, 1, 1, 0);
        check("wd_gnt", obs(), ex(3'b010, 1, 2'd1, 0));
        for (int i = 0; i < 14; i++) step(3'b010, 1, 1, 0);
        check("wd_tick14", obs(), ex(3'b010, 1, 2'd1, 0));
        step(3'b010, 1, 1, 0);
        check("wd_revoke", obs(), ex(3'b000, 0, 2'd3, 1));
        step(3'b010, 0, 1, 0);
        step(3'b010, 0, 1, 0);
        step(3'b010, 1, 1, 0);
        check("wd_blocked", obs(), ex(3'b000, 0, 2'd3, 1));
        step(3'b010, 0, 1, 0);
        step(3'b000, 0, 1, 0);
        step(3'b010, 0, 1, 0);
        step(3'b010, 1, 1, 0);
        check("wd_unblocked", obs(), ex(3'b010, 1, 2'd1, 1));
        step(3'b010, 1, 1, 1);
        check("wd_clr_err", obs(), ex(3'b010, 1, 2'd1, 0));
        step(3'b000, 1, 1, 0);
        step(3'b000, 0, 1, 0);

        // cen on every 4th clk: transitions and watchdog follow cen ticks.
        for (int i = 0; i < 3; i++) step(3'b001, 0, 0, 0);
        check("cg_idle_cen0", obs(), ex(3'b000, 0, 2'd3, 0));
        step(3'b001, 0, 1, 0);
        check("cg_busreq", obs(), ex(3'b000, 1, 2'd3, 0));
        for (int i = 0; i < 3; i++) step(3'b001, 1, 0, 0);
        check("cg_wait_cen0", obs(), ex(3'b000, 1, 2'd3, 0));
        step(3'b001, 1, 1, 0);
        check("cg_gnt", obs(), ex(3'b001, 1, 2'd0, 0));
        for (int i = 0; i < 14; i++) qstep(3'b001, 1, 0);
        check("cg_wd_counts_cen", obs(), ex(3'b001, 1, 2'd0, 0));
        qstep(3'b001, 1, 1);
        check("cg_wd_set_wins", obs(), ex(3'b000, 0, 2'd3, 1));
        qstep(3'b001, 0, 0);
        qstep(3'b000, 0, 0);
        check("cg_end", obs(), ex(3'b000, 0, 2'd3, 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/jtcps2_busarb.md
JTCPS2_BUSARB -- requirements
Module: jtcps2_busarb

Interface
REQ-001 Parameter TMO_W, default 12: watchdog width; a grant is revoked after 2^TMO_W-1 cen ticks.
REQ-002 Parameter MAXCHAIN, default 2: maximum number of grants per bus tenure (1..3).
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 cen  in  1  clock enable; the FSM, counters and input sampling advance only on clk edges with cen=1, except where REQ-019 states otherwise.
REQ-006 req  in  3  per-requester bus request, level: 0=object DMA, 1=palette DMA, 2=scroll DMA; held high for the whole transfer, dropped to release.
REQ-007 gnt  out 3  one-hot grant, registered.
REQ-008 busreq  out 1  bus request to the CPU arbitration logic, registered.
REQ-009 busack  in  1  CPU bus acknowledged (BGACK asserted).
REQ-010 owner  out 2  index of the granted requester; 3 when gnt==0.
REQ-011 timeout  out 1  sticky watchdog error flag.
REQ-012 clr_err  in  1  synchronous clear of timeout, active on any clk edge.

Function
REQ-013 The FSM shall have the states IDLE, WAIT, GRANT, SWITCH and REL; outputs shall be registered, giving 1 clk of latency from the cen-qualified decision.
REQ-014 IDLE: on cen with any req high: busreq<=1, chain<=0, go to WAIT.
REQ-015 WAIT: on cen with busack=1 and an eligible req: grant the round-robin winner, go to GRANT. With busack=1 and no eligible req: go to REL. With busack=0: remain in WAIT and hold busreq=1.
REQ-016 Round-robin: the search shall start at last_owner+1 mod 3. last_owner shall reset to 2, so requester 0 wins first after reset.
REQ-017 GRANT: on cen with req[owner]=0: gnt<=0, chain<=chain+1. If another eligible req is high and chain+1<MAXCHAIN, go to SWITCH; otherwise go to REL.
REQ-018 SWITCH: one cen tick with gnt=0 and busreq=1, then grant the next round-robin winner and go to GRANT. If no eligible req remains, go to REL.
REQ-019 A busack drop while in GRANT or SWITCH shall clear gnt on the next clk edge regardless of cen, then go to REL.
REQ-020 REL: busreq<=0. On cen with busack=0, go to IDLE. Requests seen while in REL shall wait for IDLE.
REQ-021 Watchdog: the counter shall clear on each grant and increment on each cen in GRANT.
REQ-022 When the watchdog reaches all-ones: gnt<=0, timeout<=1, set block[owner], go to REL.
REQ-023 block[i] shall make requester i ineligible, and shall clear when req[i]=0 is sampled.
REQ-024 If clr_err and a timeout set occur on the same edge, the set shall win.
REQ-025 gnt shall never have more than one bit set.
REQ-026 gnt shall be nonzero only while busack=1 and busreq=1.
REQ-027 A req dropped in WAIT before busack arrives shall simply not be granted.
REQ-028 chain shall be 2 bits wide and saturating.

Reset
REQ-029 While rst=1: state=IDLE, gnt=0, busreq=0, owner=3, timeout=0, chain=0, block=0, watchdog=0, last_owner=2. All of these shall take effect immediately (asynchronously).
REQ-030 Asserting rst mid-transfer shall drop gnt and busreq in the same cycle. No state shall survive the reset.

Verification
REQ-031 Scenario, single requester: cen=1 every clk, req=001, busack follows busreq after 3 clk -> busreq=1 one clk after req, gnt=001 and owner=0 one clk after busack. After req drops: gnt=000, busreq=0, IDLE once busack=0.
REQ-032 Scenario, chain and limit: req=111 with MAXCHAIN=2 -> grants go 0 then 1, with a one-tick SWITCH gap. After the second release, REL is entered and busreq drops. Requester 2 is granted first in the next tenure.
REQ-033 Scenario, watchdog: TMO_W=4 with req[1] held forever -> gnt revoked after 15 cen ticks, timeout=1. Requester 1 is not regranted until req[1] toggles low. clr_err then gives timeout=0.
REQ-034 Scenario, busack loss: busack drops during GRANT while cen=0 -> gnt=000 on the next clk edge, followed by REL->IDLE.
REQ-035 Scenario, reset mid-grant: rst pulses during GRANT -> gnt, busreq and owner equal 000, 0 and 3 with no clock edge required. Arbitration restarts with requester 0 winning.
REQ-036 Scenario, cen gating: cen every 4th clk -> all FSM transitions occur only on cen edges, and the watchdog counts cen ticks rather than clk cycles.
